alu_share_ctrl: RTL and testbench

Sequential controller that shares the single combinational ALU between two requesters (e.g. the execute path and a multi-cycle multiply/shift helper). It arbitrates round-robin, latches the winner's operands and control code into registers driving the ALU inputs, waits a fixed number of cycles for the gate-delay ALU to settle, then captures result and flags and returns them with a done pulse. It sits between the requesters and the ALU; the ALU itself is unchanged.

---
 rtl/alu_share_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one combinational ALU between two requesters. A round-robin
// arbiter picks a winner in IDLE, the winner's operands and control code are
// registered onto the ALU inputs, the controller waits ALU_CYCLES cycles for
// the ALU to settle, then captures result and flags and pulses the winner's
// done.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req0/req1                   requests, held high until the matching grant
//   a0/b0/op0, a1/b1/op1        operands and ALU control code per requester
//   grant0/grant1               one-cycle pulse: operands latched
//   done0/done1                 one-cycle pulse: result/flags valid
//   busy                        high whenever the controller is not idle
//   alu_a/alu_b/alu_cntrl       registered ALU inputs
//   alu_result, alu_negative, alu_zero, alu_overflow, alu_carry_out
//                               ALU outputs
//   result, negative, zero, overflow, carry_out
//                               captured ALU outputs, held until next capture
// ---------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int WIDTH      = 64,
  parameter int ALU_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  output logic             grant0,
  output logic             grant1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_CYCLES - 1);

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic             last_winner, last_winner_n;
  logic             pick;
  logic             grant0_n, grant1_n, done0_n, done1_n;
  logic [WIDTH-1:0] alu_a_n, alu_b_n, result_n;
  logic [2:0]       alu_cntrl_n;
  logic             negative_n, zero_n, overflow_n, carry_out_n;

  // busy is decoded straight from the state so it tracks IDLE exactly.
  assign busy = (state != IDLE);

  // State and datapath registers. last_winner doubles as the record of who
  // owns the operation in flight, so done is routed from it; it resets to 1
  // so that requester 0 wins the very first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_winner <= 1'b1;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cntrl   <= 3'd0;
      result      <= '0;
      negative    <= 1'b0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      carry_out   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_winner <= last_winner_n;
      grant0      <= grant0_n;
      grant1      <= grant1_n;
      done0       <= done0_n;
      done1       <= done1_n;
      alu_a       <= alu_a_n;
      alu_b       <= alu_b_n;
      alu_cntrl   <= alu_cntrl_n;
      result      <= result_n;
      negative    <= negative_n;
      zero        <= zero_n;
      overflow    <= overflow_n;
      carry_out   <= carry_out_n;
    end
  end

  // Next-state logic. Everything holds by default and grant/done default low
  // so they come out as single-cycle pulses. On a tie the requester that did
  // not win last time is chosen; with a single request that requester wins.
  // The ALU inputs are only written in IDLE, so late operand changes by a
  // requester never reach the ALU during EXEC.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    last_winner_n = last_winner;
    grant0_n      = 1'b0;
    grant1_n      = 1'b0;
    done0_n       = 1'b0;
    done1_n       = 1'b0;
    alu_a_n       = alu_a;
    alu_b_n       = alu_b;
    alu_cntrl_n   = alu_cntrl;
    result_n      = result;
    negative_n    = negative;
    zero_n        = zero;
    overflow_n    = overflow;
    carry_out_n   = carry_out;
    pick          = (req0 && req1) ? ~last_winner : req1;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          last_winner_n = pick;
          if (pick) begin
            alu_a_n     = a1;
            alu_b_n     = b1;
            alu_cntrl_n = op1;
            grant1_n    = 1'b1;
          end else begin
            alu_a_n     = a0;
            alu_b_n     = b0;
            alu_cntrl_n = op0;
            grant0_n    = 1'b1;
          end
          cnt_n   = CNT_LOAD;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          result_n    = alu_result;
          negative_n  = alu_negative;
          zero_n      = alu_zero;
          overflow_n  = alu_overflow;
          carry_out_n = alu_carry_out;
          if (last_winner) begin
            done1_n = 1'b1;
          end else begin
            done0_n = 1'b1;
          end
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
//
// Bench for alu_share_ctrl. A behavioural ALU drives the DUT's ALU inputs.
// A transaction-level reference tracks where each operation is in its
// fixed-length lifetime (grant, settle, done, back to idle) and what result
// it must return; every DUT output is compared against it each cycle.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;

  localparam int W  = 64;
  localparam int AC = 2;

  logic          clk;
  logic          reset;
  logic          req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic [2:0]    op0, op1;
  logic          grant0, grant1, done0, done1, busy;
  logic [W-1:0]  alu_a, alu_b, alu_result, result;
  logic [2:0]    alu_cntrl;
  logic          alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic          negative, zero, overflow, carry_out;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Reference state: position inside the current operation (0 = idle),
  // owner, latched operands and the result the DUT must capture.
  int            m_cyc;
  logic          m_last, m_win;
  logic [W-1:0]  m_a, m_b, m_res;
  logic [2:0]    m_op;
  logic [3:0]    m_flags;
  logic          e_g0, e_g1, e_d0, e_d1;

  alu_share_ctrl #(.WIDTH(W), .ALU_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1),
    .grant0(grant0), .grant1(grant1),
    .done0(done0), .done1(done1),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .result(result),
    .negative(negative), .zero(zero),
    .overflow(overflow), .carry_out(carry_out)
  );

  // Behavioural ALU: returns {negative, zero, overflow, carry, result}.
  // Code 7 is a fixed pattern used to exercise every flag output.
  function automatic logic [W+3:0] alu_fn(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a & b);
      3'd6: r = a;
      default: return {1'b0, 1'b1, 1'b1, 1'b1, {W{1'b0}}};
    endcase
    return {r[W-1], (r == '0), v, c, r};
  endfunction

  assign {alu_negative, alu_zero, alu_overflow, alu_carry_out, alu_result} =
    alu_fn(alu_cntrl, alu_a, alu_b);

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  // Advances the reference by one clock edge using the inputs just sampled.
  task automatic modelStep();
    e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
    if (reset) begin
      m_cyc = 0; m_last = 1'b1; m_win = 1'b1;
      m_a = '0; m_b = '0; m_op = 3'd0; m_res = '0; m_flags = 4'd0;
    end else if (m_cyc == 0) begin
      if (req0 || req1) begin
        m_win  = (req0 && req1) ? (m_last ? 1'b0 : 1'b1) : req1;
        m_last = m_win;
        m_a    = m_win ? a1 : a0;
        m_b    = m_win ? b1 : b0;
        m_op   = m_win ? op1 : op0;
        if (m_win) e_g1 = 1'b1; else e_g0 = 1'b1;
        m_cyc  = 1;
      end
    end else begin
      m_cyc++;
      if (m_cyc == AC + 1) begin
        {m_flags, m_res} = alu_fn(m_op, m_a, m_b);
        if (m_win) e_d1 = 1'b1; else e_d0 = 1'b1;
      end else if (m_cyc == AC + 2) begin
        m_cyc = 0;
      end
    end
  endtask

  // Compares every DUT output with the reference for the current cycle.
  task automatic checkCycle();
    checkOutput("grant0", W'(grant0), W'(e_g0));
    checkOutput("grant1", W'(grant1), W'(e_g1));
    checkOutput("done0", W'(done0), W'(e_d0));
    checkOutput("done1", W'(done1), W'(e_d1));
    checkOutput("busy", W'(busy), W'(m_cyc != 0));
    checkOutput("alu_a", alu_a, m_a);
    checkOutput("alu_b", alu_b, m_b);
    checkOutput("alu_cntrl", W'(alu_cntrl), W'(m_op));
    checkOutput("result", result, m_res);
    checkOutput("flags", W'({negative, zero, overflow, carry_out}), W'(m_flags));
  endtask

  // Drives one cycle of inputs away from the edge, then checks after it.
  task automatic applyStimulus(input logic r, input logic q0, input logic q1,
                               input logic [W-1:0] a0v, input logic [W-1:0] b0v,
                               input logic [2:0] o0v,
                               input logic [W-1:0] a1v, input logic [W-1:0] b1v,
                               input logic [2:0] o1v);
    @(negedge clk);
    reset = r; req0 = q0; req1 = q1;
    a0 = a0v; b0 = b0v; op0 = o0v;
    a1 = a1v; b1 = b1v; op1 = o1v;
    @(posedge clk);
    modelStep();
    #1;
    cycle++;
    checkCycle();
  endtask

  function automatic logic [W-1:0] randVal();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = 3'd0; op1 = 3'd0;
    m_cyc = 0; m_last = 1'b1; m_win = 1'b1;
    m_a = '0; m_b = '0; m_op = 3'd0; m_res = '0; m_flags = 4'd0;
    e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;

    // Reset held with req0 pending: nothing may be granted.
    repeat (2) applyStimulus(1, 1, 0, 64'd5, 64'd3, 3'd0, 64'd9, 64'd9, 3'd1);

    // Single add 5+3 from requester 0; a0 changes after the grant.
    applyStimulus(0, 1, 0, 64'd5, 64'd3, 3'd0, 64'd9, 64'd9, 3'd1);
    repeat (5) applyStimulus(0, 0, 0, 64'hFFFF, 64'd3, 3'd0, 64'd9, 64'd9, 3'd1);

    // Flag pattern from requester 1, then idle cycles with flags held.
    applyStimulus(0, 0, 1, 64'd1, 64'd1, 3'd0, 64'd7, 64'd7, 3'd7);
    repeat (6) applyStimulus(0, 0, 0, 64'd1, 64'd1, 3'd0, 64'd7, 64'd7, 3'd7);

    // Continuous tie: grants must alternate starting with requester 0.
    repeat (20) applyStimulus(0, 1, 1, 64'h10, 64'h20, 3'd0,
                              64'h300, 64'h100, 3'd1);
    repeat (4) applyStimulus(0, 0, 0, 64'd0, 64'd0, 3'd0, 64'd0, 64'd0, 3'd0);

    // Reset asserted in cycle 2 of an operation, then a fresh request.
    applyStimulus(0, 1, 0, 64'hAA, 64'h55, 3'd4, 64'd0, 64'd0, 3'd0);
    applyStimulus(0, 0, 0, 64'hAA, 64'h55, 3'd4, 64'd0, 64'd0, 3'd0);
    applyStimulus(1, 0, 0, 64'hAA, 64'h55, 3'd4, 64'd0, 64'd0, 3'd0);
    applyStimulus(0, 0, 1, 64'd0, 64'd0, 3'd0, 64'hF0, 64'h0F, 3'd3);
    repeat (5) applyStimulus(0, 0, 0, 64'd0, 64'd0, 3'd0, 64'd0, 64'd0, 3'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    randVal(), randVal(), 3'($urandom_range(0, 7)),
                    randVal(), randVal(), 3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
